register_file: RTL and testbench
================================

# register_file

Parametrised multi-register storage for the Hmmm datapath: the next generation of the single bus register. It holds DEPTH registers of N bits, with one write port and two independent registered read ports. Register 0 is optionally hard-wired to zero. Storage is a reset-free array cleared by an internal sweep sequencer after reset, keeping reset fanout off the array. It sits between the instruction decoder (addresses) and the ALU/bus muxing (data). There are no tri-states; all outputs are always driven.

## Interface
- N, 16, data width in bits
- DEPTH, 16, number of registers (≥2; need not be a power of two)
- ZERO_REG, 1, when 1 register 0 always reads 0 and ignores writes
- AW (localparam), $clog2(DEPTH), address width
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- we  in  1  write enable
- waddr  in  AW  write address
- wdata  in  N  write data
- re_a  in  1  read enable, port A
- raddr_a  in  AW  read address, port A
- rdata_a  out  N  read data, port A (registered)
- re_b  in  1  read enable, port B
- raddr_b  in  AW  read address, port B
- rdata_b  out  N  read data, port B (registered)
- busy  out  1  clear sweep in progress; all requests ignored while high

## Operation
- FSM states: CLEAR and RUN. rst forces CLEAR with sweep pointer ptr=0.
- CLEAR:
  - Each edge with rst low writes 0 to mem[ptr] and increments ptr.
  - The edge that clears mem[DEPTH-1] moves the FSM to RUN.
  - we, re_a and re_b are ignored; rdata_a and rdata_b are held at 0.
- RUN, write: on an edge with we=1, mem[waddr] <= wdata.
  - The write is dropped if waddr ≥ DEPTH.
  - The write is dropped if waddr==0 and ZERO_REG=1.
- RUN, read: on an edge with re_x=1, rdata_x <= mem[raddr_x].
  - The read returns 0 if raddr_x ≥ DEPTH.
  - The read returns 0 if raddr_x==0 and ZERO_REG=1.
  - With re_x=0, rdata_x holds its previous value.
- Bypass: if we=1, re_x=1 and raddr_x==waddr on the same edge, and the write is not dropped, rdata_x <= wdata (new data, not old).
- Ports A and B are fully independent. Both may read the same address. Both may bypass on the same edge.

## Timing
- Reset values while rst=1: busy=1, rdata_a=0, rdata_b=0, ptr=0. Array contents are undefined until the sweep completes.
- Sweep length: busy stays high for exactly DEPTH rising edges after rst deasserts. busy is low from the DEPTH-th edge onward.
- The first request is accepted on the edge after busy is sampled low.
- rst asserted mid-sweep or in RUN restarts the sweep from ptr=0 on the next edge.
- Read latency is 1 cycle: the address is sampled on edge k and the data is valid after edge k.
- Write latency is 1 cycle. A non-bypassed read on edge k+1 sees a write made on edge k.
- busy is a registered output, with no combinational path from any input.

## Structure
- Shared package hmmm_pkg holds:
  - HMMM_WORD_W = 16
  - HMMM_NUM_REGS = 16
  - HMMM_REG_ZERO = 0
  - the 2-state FSM enum
- The top instantiates with the package constants.
- One sub-module is natural: regfile_clear_seq, which owns the FSM, ptr and busy. It outputs clr_we and clr_addr, which are muxed onto the array write port.
- Read/bypass logic and the array stay in register_file.

## Test plan
- Reset sweep: DEPTH=16, pulse rst for 2 cycles.
  - busy is high for exactly 16 edges after release.
  - A read of all addresses 0..15 afterwards returns 0x0000.
- Write/readback: write 0xBEEF to r5, then read r5 on port A and r3 on port B on the next edge.
  - rdata_a=0xBEEF, rdata_b=0x0000, each one cycle after the read.
- Zero register: with ZERO_REG=1, write 0x1234 to r0, then read r0.
  - rdata=0x0000.
  - With ZERO_REG=0, the same sequence returns 0x1234.
- Bypass: r7=0x0001; same edge we=1, waddr=7, wdata=0x00FF, re_a=re_b=1, raddr_a=raddr_b=7.
  - Both ports return 0x00FF.
  - The next read of r7 also returns 0x00FF.
- Hold and range: DEPTH=12, write 0xAAAA to r11 and attempt a write to address 13, then read 13 and r11.
  - Address 13 returns 0 and no register changes.
  - After reading r11, hold re_a low for 3 cycles: rdata_a stays 0xAAAA.
- Reset mid-operation: assert rst at sweep step 6, and separately during RUN with we=1.
  - The sweep restarts at 0, the write is discarded, busy re-asserts immediately, and rdata returns to 0.

Source files
------------

// File: rtl/hmmm_pkg.sv
// Shared constants and types for the Hmmm datapath register storage.
package hmmm_pkg;

    localparam int HMMM_WORD_W   = 16;
    localparam int HMMM_NUM_REGS = 16;
    localparam int HMMM_REG_ZERO = 0;

    // Clear sequencer states: CLEAR sweeps zeros into the array, RUN serves requests.
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } rf_state_e;

endpackage

// File: rtl/register_file_if.sv
// Request/response bundle between the decoder/ALU side and the register file.
//
// Request semantics: we, re_a and re_b are single-cycle qualifiers sampled on
// the rising edge of clk together with their address/data. busy acts as the
// inverse of ready: while busy is high every request is ignored (no retry and
// no queueing), so the master must see busy low before presenting requests.
interface register_file_if
    import hmmm_pkg::*;
#(
    parameter int N  = HMMM_WORD_W,
    parameter int AW = $clog2(HMMM_NUM_REGS)
);

    logic          we;
    logic [AW-1:0] waddr;
    logic [N-1:0]  wdata;
    logic          re_a;
    logic [AW-1:0] raddr_a;
    logic [N-1:0]  rdata_a;
    logic          re_b;
    logic [AW-1:0] raddr_b;
    logic [N-1:0]  rdata_b;
    logic          busy;

    modport master (
        output we, waddr, wdata, re_a, raddr_a, re_b, raddr_b,
        input  rdata_a, rdata_b, busy
    );

    modport slave (
        input  we, waddr, wdata, re_a, raddr_a, re_b, raddr_b,
        output rdata_a, rdata_b, busy
    );

endinterface

// File: rtl/regfile_clear_seq.sv
// Post-reset clear sequencer: walks a pointer over every register, emitting a
// zero-write each cycle, then hands the array over to normal operation.
module regfile_clear_seq
    import hmmm_pkg::*;
#(
    parameter int DEPTH = HMMM_NUM_REGS,
    parameter int AW    = $clog2(HMMM_NUM_REGS)
) (
    input  logic          clk,
    input  logic          rst,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr,
    output logic          busy,
    output rf_state_e     state
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    logic [AW-1:0] ptr;

    // Sweep FSM: reset parks at CLEAR/ptr 0; the edge clearing the last entry enters RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_CLEAR;
            ptr   <= '0;
            busy  <= 1'b1;
        end else begin
            case (state)
                ST_CLEAR: begin
                    if (ptr == LAST) begin
                        state <= ST_RUN;
                        busy  <= 1'b0;
                        ptr   <= '0;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
                ST_RUN: begin
                    state <= ST_RUN;
                end
                default: begin
                    state <= ST_CLEAR;
                    ptr   <= '0;
                    busy  <= 1'b1;
                end
            endcase
        end
    end

    // Zero-write strobe; suppressed while rst is high so only released edges count as sweep steps.
    always_comb begin
        clr_we   = (state == ST_CLEAR) && !rst;
        clr_addr = ptr;
    end

endmodule

// File: rtl/register_file.sv
// Multi-register storage: one write port, two independent registered read
// ports with write-to-read bypass, optional hard-wired zero register, and a
// reset-free array cleared by the sweep sequencer.
module register_file
    import hmmm_pkg::*;
#(
    parameter int N        = HMMM_WORD_W,
    parameter int DEPTH    = HMMM_NUM_REGS,
    parameter int ZERO_REG = 1
) (
    input  logic           clk,
    input  logic           rst,
    register_file_if.slave bus
);

    localparam int            AW        = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_W   = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] ZERO_ADDR = AW'(HMMM_REG_ZERO);

    logic [N-1:0]  mem [DEPTH];
    logic          clr_we;
    logic [AW-1:0] clr_addr;
    logic          busy;
    rf_state_e     state;
    logic          run;
    logic          wr_ok;
    logic [N-1:0]  rdata_a_q;
    logic [N-1:0]  rdata_b_q;

    regfile_clear_seq #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_clear_seq (
        .clk      (clk),
        .rst      (rst),
        .clr_we   (clr_we),
        .clr_addr (clr_addr),
        .busy     (busy),
        .state    (state)
    );

    // An address maps to real storage when it is in range and not the hard-wired zero.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return ({1'b0, a} < DEPTH_W) && !((ZERO_REG != 0) && (a == ZERO_ADDR));
    endfunction

    // Read value for one port: bypassed write data, stored word, or zero.
    function automatic logic [N-1:0] read_val(
        input logic [AW-1:0] ra,
        input logic          wok,
        input logic [AW-1:0] wa,
        input logic [N-1:0]  wd,
        input logic [N-1:0]  stored
    );
        if (wok && (ra == wa)) begin
            return wd;
        end else if (addr_ok(ra)) begin
            return stored;
        end else begin
            return '0;
        end
    endfunction

    // Qualify the user write: only in RUN, outside reset, to a writable register.
    always_comb begin
        run   = (state == ST_RUN);
        wr_ok = run && !rst && bus.we && addr_ok(bus.waddr);
    end

    // Array write port: the clear sweep has priority, otherwise the qualified user write.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (wr_ok) begin
            mem[bus.waddr] <= bus.wdata;
        end
    end

    // Port A read register: zero during reset/sweep, holds when re_a is low.
    always_ff @(posedge clk) begin
        if (rst || !run) begin
            rdata_a_q <= '0;
        end else if (bus.re_a) begin
            rdata_a_q <= read_val(bus.raddr_a, wr_ok, bus.waddr, bus.wdata, mem[bus.raddr_a]);
        end
    end

    // Port B read register: same rules as port A, fully independent.
    always_ff @(posedge clk) begin
        if (rst || !run) begin
            rdata_b_q <= '0;
        end else if (bus.re_b) begin
            rdata_b_q <= read_val(bus.raddr_b, wr_ok, bus.waddr, bus.wdata, mem[bus.raddr_b]);
        end
    end

    assign bus.rdata_a = rdata_a_q;
    assign bus.rdata_b = rdata_b_q;
    assign bus.busy    = busy;

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: three instances (16 regs with zero reg, 16 regs
// without, 12 regs with zero reg) driven by identical stimulus and compared
// each cycle against an array-based reference model.
module tb_register_file;
    import hmmm_pkg::*;

    logic clk;
    logic rst;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_q[$];

    register_file_if #(.N(16), .AW(4)) if0 ();
    register_file_if #(.N(16), .AW(4)) if1 ();
    register_file_if #(.N(16), .AW(4)) if2 ();

    register_file #(.N(16), .DEPTH(16), .ZERO_REG(1)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
    register_file #(.N(16), .DEPTH(16), .ZERO_REG(0)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
    register_file #(.N(16), .DEPTH(12), .ZERO_REG(1)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

    wire [15:0] o_ra   [3];
    wire [15:0] o_rb   [3];
    wire        o_busy [3];
    assign o_ra[0] = if0.rdata_a;  assign o_rb[0] = if0.rdata_b;  assign o_busy[0] = if0.busy;
    assign o_ra[1] = if1.rdata_a;  assign o_rb[1] = if1.rdata_b;  assign o_busy[1] = if1.busy;
    assign o_ra[2] = if2.rdata_a;  assign o_rb[2] = if2.rdata_b;  assign o_busy[2] = if2.busy;

    // Reference model state, one slot per instance.
    int          m_depth [3] = '{16, 16, 12};
    int          m_zero  [3] = '{1, 0, 1};
    logic [15:0] m_mem   [3][16];
    int          m_left  [3] = '{16, 16, 12};
    logic        m_busy  [3] = '{1'b1, 1'b1, 1'b1};
    logic [15:0] m_ra    [3] = '{16'h0, 16'h0, 16'h0};
    logic [15:0] m_rb    [3] = '{16'h0, 16'h0, 16'h0};

    // clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic storable(int d, int a);
        return (a < m_depth[d]) && !(m_zero[d] != 0 && a == 0);
    endfunction

    // One clock edge as the model sees it.
    task automatic model_edge(input int d, input logic r, input logic w, input int wa,
                              input logic [15:0] wd, input logic rea, input int raa,
                              input logic reb, input int rba);
        logic wok;
        if (r) begin
            m_busy[d] = 1'b1; m_ra[d] = 16'h0; m_rb[d] = 16'h0; m_left[d] = m_depth[d];
        end else if (m_left[d] > 0) begin
            m_left[d]--;
            m_ra[d] = 16'h0; m_rb[d] = 16'h0;
            if (m_left[d] == 0) begin
                for (int i = 0; i < 16; i++) m_mem[d][i] = 16'h0;
            end
            m_busy[d] = (m_left[d] > 0);
        end else begin
            wok = w && storable(d, wa);
            if (rea) m_ra[d] = (wok && raa == wa) ? wd : (storable(d, raa) ? m_mem[d][raa] : 16'h0);
            if (reb) m_rb[d] = (wok && rba == wa) ? wd : (storable(d, rba) ? m_mem[d][rba] : 16'h0);
            if (wok) m_mem[d][wa] = wd;
            m_busy[d] = 1'b0;
        end
    endtask

    // driver: apply one cycle of stimulus to all instances, advance, compare with model
    task automatic step(input logic r, input logic w, input logic [3:0] wa, input logic [15:0] wd,
                        input logic rea, input logic [3:0] raa, input logic reb, input logic [3:0] rba);
        rst = r;
        if0.we = w; if0.waddr = wa; if0.wdata = wd; if0.re_a = rea; if0.raddr_a = raa; if0.re_b = reb; if0.raddr_b = rba;
        if1.we = w; if1.waddr = wa; if1.wdata = wd; if1.re_a = rea; if1.raddr_a = raa; if1.re_b = reb; if1.raddr_b = rba;
        if2.we = w; if2.waddr = wa; if2.wdata = wd; if2.re_a = rea; if2.raddr_a = raa; if2.re_b = reb; if2.raddr_b = rba;
        @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            model_edge(d, r, w, int'(wa), wd, rea, int'(raa), reb, int'(rba));
            checks++;
            if (o_busy[d] !== m_busy[d]) begin
                errors++;
                $display("FAIL model_busy dut%0d got %b expected %b at %0t", d, o_busy[d], m_busy[d], $time);
            end
            checks++;
            if (o_ra[d] !== m_ra[d]) begin
                errors++;
                $display("FAIL model_rdata_a dut%0d got %h expected %h at %0t", d, o_ra[d], m_ra[d], $time);
            end
            checks++;
            if (o_rb[d] !== m_rb[d]) begin
                errors++;
                $display("FAIL model_rdata_b dut%0d got %h expected %h at %0t", d, o_rb[d], m_rb[d], $time);
            end
        end
    endtask

    task automatic idle(input logic r);
        step(r, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 1'b0, 4'd0);
    endtask

    // Release reset and measure how many edges each instance stays busy.
    task automatic run_sweep(input string tag);
        int n [3] = '{0, 0, 0};
        for (int e = 1; e <= 40; e++) begin
            idle(1'b0);
            for (int d = 0; d < 3; d++) if (n[d] == 0 && o_busy[d] === 1'b0) n[d] = e;
            if (n[0] != 0 && n[1] != 0 && n[2] != 0) break;
        end
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (n[d] != m_depth[d]) begin
                errors++;
                $display("FAIL %s_sweep_len dut%0d got %0d expected %0d", tag, d, n[d], m_depth[d]);
            end
        end
    endtask

    task automatic test_reset;
        idle(1'b1);
        idle(1'b1);
        checks++;
        if (if0.busy !== 1'b1 || if0.rdata_a !== 16'h0 || if0.rdata_b !== 16'h0) begin
            errors++;
            $display("FAIL reset_values got busy=%b a=%h b=%h expected busy=1 a=0000 b=0000",
                     if0.busy, if0.rdata_a, if0.rdata_b);
        end
        run_sweep("reset");
        for (int a = 0; a < 16; a++) begin
            step(1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 4'(a), 1'b1, 4'(15 - a));
            exp_q.push_back(16'h0000);
            exp_q.push_back(16'h0000);
            checks++;
            if (if0.rdata_a !== exp_q.pop_front()) begin
                errors++;
                $display("FAIL cleared_read_a addr %0d got %h expected 0000", a, if0.rdata_a);
            end
            checks++;
            if (if0.rdata_b !== exp_q.pop_front()) begin
                errors++;
                $display("FAIL cleared_read_b addr %0d got %h expected 0000", 15 - a, if0.rdata_b);
            end
        end
    endtask

    task automatic test_write_readback;
        step(1'b0, 1'b1, 4'd5, 16'hBEEF, 1'b0, 4'd0, 1'b0, 4'd0);
        step(1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 4'd5, 1'b1, 4'd3);
        checks++;
        if (if0.rdata_a !== 16'hBEEF || if0.rdata_b !== 16'h0000) begin
            errors++;
            $display("FAIL write_readback got a=%h b=%h expected a=beef b=0000", if0.rdata_a, if0.rdata_b);
        end
    endtask

    task automatic test_zero_reg;
        step(1'b0, 1'b1, 4'd0, 16'h1234, 1'b0, 4'd0, 1'b0, 4'd0);
        step(1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 4'd0, 1'b1, 4'd0);
        checks++;
        if (if0.rdata_a !== 16'h0000 || if0.rdata_b !== 16'h0000) begin
            errors++;
            $display("FAIL zero_reg_on got a=%h b=%h expected 0000", if0.rdata_a, if0.rdata_b);
        end
        checks++;
        if (if1.rdata_a !== 16'h1234 || if1.rdata_b !== 16'h1234) begin
            errors++;
            $display("FAIL zero_reg_off got a=%h b=%h expected 1234", if1.rdata_a, if1.rdata_b);
        end
    endtask

    task automatic test_bypass;
        step(1'b0, 1'b1, 4'd7, 16'h0001, 1'b0, 4'd0, 1'b0, 4'd0);
        step(1'b0, 1'b1, 4'd7, 16'h00FF, 1'b1, 4'd7, 1'b1, 4'd7);
        checks++;
        if (if0.rdata_a !== 16'h00FF || if0.rdata_b !== 16'h00FF) begin
            errors++;
            $display("FAIL bypass got a=%h b=%h expected 00ff", if0.rdata_a, if0.rdata_b);
        end
        step(1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 4'd7, 1'b0, 4'd0);
        checks++;
        if (if0.rdata_a !== 16'h00FF) begin
            errors++;
            $display("FAIL bypass_persist got %h expected 00ff", if0.rdata_a);
        end
    endtask

    task automatic test_hold_range;
        step(1'b0, 1'b1, 4'd11, 16'hAAAA, 1'b0, 4'd0, 1'b0, 4'd0);
        step(1'b0, 1'b1, 4'd13, 16'h5555, 1'b0, 4'd0, 1'b0, 4'd0);
        step(1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 4'd13, 1'b1, 4'd11);
        checks++;
        if (if2.rdata_a !== 16'h0000 || if2.rdata_b !== 16'hAAAA) begin
            errors++;
            $display("FAIL out_of_range got a=%h b=%h expected a=0000 b=aaaa", if2.rdata_a, if2.rdata_b);
        end
        // every register of the 12-entry instance must be untouched by the dropped write
        for (int a = 0; a < 12; a++) step(1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 4'(a), 1'b0, 4'd0);
        step(1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 4'd11, 1'b0, 4'd0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 4'd11, 16'h0F0F, 1'b0, 4'd11, 1'b0, 4'd0);
            checks++;
            if (if2.rdata_a !== 16'hAAAA) begin
                errors++;
                $display("FAIL hold_cycle%0d got %h expected aaaa", i, if2.rdata_a);
            end
        end
    endtask

    task automatic test_reset_mid;
        idle(1'b1);
        for (int i = 0; i < 6; i++) idle(1'b0);
        step(1'b1, 1'b1, 4'd3, 16'h3333, 1'b1, 4'd3, 1'b0, 4'd0);
        checks++;
        if (if0.busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_sweep_busy got %b expected 1", if0.busy);
        end
        run_sweep("mid_sweep");
        step(1'b0, 1'b1, 4'd2, 16'h4444, 1'b1, 4'd9, 1'b1, 4'd9);
        step(1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 4'd2, 1'b0, 4'd0);
        step(1'b1, 1'b1, 4'd2, 16'h7777, 1'b1, 4'd2, 1'b1, 4'd2);
        checks++;
        if (if0.busy !== 1'b1 || if0.rdata_a !== 16'h0 || if0.rdata_b !== 16'h0) begin
            errors++;
            $display("FAIL run_reset got busy=%b a=%h b=%h expected busy=1 a=0000 b=0000",
                     if0.busy, if0.rdata_a, if0.rdata_b);
        end
        run_sweep("run_reset");
        step(1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 4'd2, 1'b0, 4'd0);
        checks++;
        if (if0.rdata_a !== 16'h0000) begin
            errors++;
            $display("FAIL discarded_write got %h expected 0000", if0.rdata_a);
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 99) == 0,
                 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 16'($urandom),
                 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
        end
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_write_readback();
        test_zero_reg();
        test_bypass();
        test_hold_range();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
